// File: rtl/nios2_pio_pkg.sv
// Shared constants for the Nios II input PIO: register addresses and the
// EDGE_TYPE / IRQ_MODE parameter encodings.
package nios2_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;

  localparam int BUS_WIDTH = 32;

endpackage

// File: rtl/nios2_pio_in_irq_if.sv
// Avalon-MM slave bus of the input PIO: word address, select, write strobe,
// write data and registered read data (fixed 1-cycle read latency).
interface nios2_pio_in_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/nios2_pio_sync_edge.sv
// Input synchroniser, one-clock delayed copy and primed per-bit edge detector.
// data_sync lags in_port by SYNC_STAGES clocks; edge_vec is combinational from the flops.
module nios2_pio_sync_edge
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_sync,
  output logic [WIDTH-1:0] edge_vec
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] d_prev;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_raw;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign data_sync = in_port;
  end else begin : g_sync
    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      end else begin
        chain[0] <= in_port;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end

    assign data_sync = chain[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev <= '0;
    end else begin
      d_prev <= data_sync;
    end
  end

  // Edges are suppressed until the chain and d_prev hold real samples, so a
  // line that was already high across reset release is not seen as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 3'd0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign primed = (prime_cnt == PRIME_MAX);

  always_comb begin
    rise = data_sync & ~d_prev;
    fall = ~data_sync & d_prev;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_raw = rise;
      EDGE_FALLING: edge_raw = fall;
      default:      edge_raw = rise | fall;
    endcase
    edge_vec = primed ? edge_raw : '0;
  end

endmodule

// File: rtl/nios2_pio_in_irq.sv
// Avalon-MM input PIO with sticky W1C edge capture, interrupt mask and registered irq.
// readdata follows the address every clock (1-cycle latency); the slave never stalls.
module nios2_pio_in_irq
  import nios2_pio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               IRQ_MODE    = IRQ_EDGE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  nios2_pio_in_irq_if.slave   bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0]     data_sync;
  logic [WIDTH-1:0]     edge_vec;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     edge_capture;
  logic [WIDTH-1:0]     capture_next;
  logic [WIDTH-1:0]     wr_dat;
  logic [BUS_WIDTH-1:0] rd_mux;
  logic [BUS_WIDTH-1:0] readdata_q;
  logic                 wr;
  logic                 wr_mask;
  logic                 wr_edge;
  logic                 irq_src;
  logic                 unused_wd;

  nios2_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .data_sync (data_sync),
    .edge_vec  (edge_vec)
  );

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_mask   = wr & (bus.address == PIO_ADDR_MASK);
  assign wr_edge   = wr & (bus.address == PIO_ADDR_EDGE);
  assign wr_dat    = bus.writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, bus.writedata};

  // OR-ing the new edge in after the clear means a coincident set always wins.
  assign capture_next = (edge_capture & ~(wr_edge ? wr_dat : '0)) | edge_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= RESET_VALUE;
      edge_capture <= '0;
    end else begin
      if (wr_mask) irq_mask <= wr_dat;
      edge_capture <= capture_next;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      PIO_ADDR_DATA: rd_mux = BUS_WIDTH'(data_sync);
      PIO_ADDR_MASK: rd_mux = BUS_WIDTH'(irq_mask);
      PIO_ADDR_EDGE: rd_mux = BUS_WIDTH'(edge_capture);
      default:       rd_mux = '0;
    endcase
  end

  if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
    assign irq_src = |(data_sync & irq_mask);
  end else begin : g_irq_edge
    assign irq_src = |(edge_capture & irq_mask);
  end

  // The mux samples pre-write state, so a read that coincides with a W1C
  // returns the value before the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq        <= 1'b0;
    end else begin
      readdata_q <= rd_mux;
      irq        <= irq_src;
    end
  end

  assign bus.readdata = readdata_q;

endmodule
